// File: rtl/edge_pkg.sv
// Shared types and default geometry for the edge-detection line-buffer control path.
package edge_pkg;

  localparam int unsigned IMG_W_DEF   = 512;
  localparam int unsigned IMG_H_DEF   = 512;
  localparam int unsigned NUM_BUF_DEF = 4;
  localparam int unsigned COL_W       = $clog2(IMG_W_DEF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  typedef logic [1:0] buf_idx_t;

endpackage

// File: rtl/line_col_counter.sv
// Column counter with enable; wraps at LEN-1 and flags the wrap in the same cycle.
module line_col_counter
  import edge_pkg::*;
#(
  parameter int unsigned LEN = IMG_W_DEF,
  parameter int unsigned CW  = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [CW-1:0] col_o,
  output logic          wrap_o
);

  logic [CW-1:0] col_q, col_d;

  assign wrap_o = en_i && (col_q == CW'(LEN - 1));
  assign col_o  = col_q;

  always_comb begin
    col_d = col_q;
    if (en_i) col_d = wrap_o ? '0 : col_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_q <= '0;
    else        col_q <= col_d;
  end

endmodule

// File: rtl/line_buffer_scheduler.sv
// Steers stream pixels into a ring of line RAMs and sequences 3-line window reads.
module line_buffer_scheduler
  import edge_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned NUM_BUF = NUM_BUF_DEF
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_BUF-1:0]       wr_en,
  output logic [$clog2(IMG_W)-1:0] wr_addr,
  input  logic                     out_ready,
  output logic                     rd_en,
  output logic [1:0]               rd_top,
  output logic [$clog2(IMG_W)-1:0] rd_addr,
  output logic                     win_valid,
  output logic                     INT,
  output logic                     frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned FW = $clog2(NUM_BUF + 1);
  localparam int unsigned RW = $clog2(IMG_H + 1);

  state_e        state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  buf_idx_t      wr_idx_q, wr_idx_d;
  buf_idx_t      rd_top_q, rd_top_d;
  logic [RW-1:0] row_q, row_d;
  logic          int_q, fd_q, wv_q;
  logic          accept, wr_done, rd_done, row_last;
  logic [CW-1:0] wr_col, rd_col;

  // A full bank (every line written but not yet consumed) back-pressures the host.
  assign in_ready   = (fill_q != FW'(NUM_BUF));
  assign accept     = in_valid && in_ready;
  assign wr_en      = accept ? (NUM_BUF'(1) << wr_idx_q) : '0;
  assign wr_addr    = wr_col;
  assign rd_en      = (state_q == ST_READ) && out_ready;
  assign rd_addr    = rd_col;
  assign rd_top     = rd_top_q;
  assign win_valid  = wv_q;
  assign INT        = int_q;
  assign frame_done = fd_q;
  assign row_last   = rd_done && (row_q == RW'(IMG_H - 1));

  line_col_counter #(.LEN(IMG_W), .CW(CW)) u_wr_col (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .en_i   (accept),
    .col_o  (wr_col),
    .wrap_o (wr_done)
  );

  line_col_counter #(.LEN(IMG_W), .CW(CW)) u_rd_col (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .en_i   (rd_en),
    .col_o  (rd_col),
    .wrap_o (rd_done)
  );

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    wr_idx_d = wr_idx_q;
    rd_top_d = rd_top_q;
    row_d    = row_q;
    case (state_q)
      ST_IDLE: if (fill_q >= FW'(3)) state_d = ST_READ;
      ST_READ: if (rd_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (wr_done) wr_idx_d = wr_idx_q + 2'd1;
    if (rd_done) begin
      rd_top_d = rd_top_q + 2'd1;
      row_d    = row_q + RW'(1);
    end
    case ({wr_done, rd_done})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    // End of frame: drop the two trailing padding lines and restart the ring.
    if (row_last) begin
      row_d    = '0;
      rd_top_d = '0;
      wr_idx_d = '0;
      fill_d   = '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      fill_q   <= '0;
      wr_idx_q <= '0;
      rd_top_q <= '0;
      row_q    <= '0;
      int_q    <= 1'b0;
      fd_q     <= 1'b0;
      wv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      wr_idx_q <= wr_idx_d;
      rd_top_q <= rd_top_d;
      row_q    <= row_d;
      int_q    <= rd_done;
      fd_q     <= row_last;
      wv_q     <= rd_en;
    end
  end

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Bench for line_buffer_scheduler: pixel-count reference model plus directed timing pins.
module tb_line_buffer_scheduler;

  localparam int W  = 16;
  localparam int H  = 6;
  localparam int NB = 4;
  localparam int CW = $clog2(W);

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, rd_en, win_valid, INT, frame_done;
  logic [NB-1:0] wr_en;
  logic [CW-1:0] wr_addr, rd_addr;
  logic [1:0]    rd_top;

  line_buffer_scheduler #(.IMG_W(W), .IMG_H(H), .NUM_BUF(NB)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .out_ready(out_ready), .rd_en(rd_en),
    .rd_top(rd_top), .rd_addr(rd_addr), .win_valid(win_valid), .INT(INT),
    .frame_done(frame_done)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state is just pixel counts written/read in the current frame.
  int m_wr, m_rd;
  bit m_reading, m_int, m_fd, m_wv;
  int cyc, int_cnt, fd_cnt, acc_cnt;
  int fill;
  bit e_ir, acc, e_rd, rd_done;

  logic [NB-1:0] lg_wren [0:255];
  logic [CW-1:0] lg_wa   [0:255];
  logic [CW-1:0] lg_ra   [0:255];
  logic [1:0]    lg_top  [0:255];
  logic          lg_rd   [0:255];
  logic          lg_int  [0:255];
  logic          lg_ir   [0:255];

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_top", rd_top, 0);
      chk("rst_addrs", {wr_addr, rd_addr}, 0);
      chk("rst_flags", {win_valid, INT, frame_done}, 0);
      m_wr = 0; m_rd = 0; m_reading = 0; m_int = 0; m_fd = 0; m_wv = 0;
      cyc = 0; int_cnt = 0; fd_cnt = 0; acc_cnt = 0;
    end else begin
      fill = m_wr / W - m_rd / W;
      e_ir = (fill != NB);
      acc  = in_valid && e_ir;
      e_rd = m_reading && out_ready;
      chk("in_ready", in_ready, e_ir);
      chk("wr_en", wr_en, acc ? (1 << ((m_wr / W) % NB)) : 0);
      chk("wr_addr", wr_addr, m_wr % W);
      chk("rd_en", rd_en, e_rd);
      chk("rd_addr", rd_addr, m_rd % W);
      chk("rd_top", rd_top, (m_rd / W) % NB);
      chk("win_valid", win_valid, m_wv);
      chk("INT", INT, m_int);
      chk("frame_done", frame_done, m_fd);
      if (cyc < 256) begin
        lg_wren[cyc] = wr_en; lg_wa[cyc] = wr_addr; lg_ra[cyc] = rd_addr;
        lg_top[cyc] = rd_top; lg_rd[cyc] = rd_en; lg_int[cyc] = INT; lg_ir[cyc] = in_ready;
      end
      if (INT === 1'b1) int_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (in_valid && in_ready) acc_cnt++;
      rd_done   = e_rd && (m_rd % W == W - 1);
      m_reading = m_reading ? !rd_done : (fill >= 3);
      m_wv      = e_rd;
      m_int     = rd_done;
      m_wr      = m_wr + int'(acc);
      m_rd      = m_rd + int'(e_rd);
      m_fd      = rd_done && (m_rd / W == H);
      if (m_fd) begin
        m_rd = 0;
        m_wr = m_wr % W;
      end
      cyc++;
    end
  end

  task automatic do_reset(input bit iv, input bit ordy);
    @(posedge ACLK); #1;
    ARESETn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1; in_valid = iv; out_ready = ordy;
  endtask

  int first_rd, first_int, last_rd, n, k;
  bit hit;

  initial begin
    // Phase 1: continuous stream, one dropped valid so a write wrap meets a read wrap.
    do_reset(1'b1, 1'b1);
    for (int i = 1; i < 100; i++) begin
      @(posedge ACLK); #1;
      in_valid = (i != 69);
    end
    @(negedge ACLK); #1;
    chk("p1_wren_line0", lg_wren[0], 4'b0001);
    chk("p1_wren_line1", lg_wren[W], 4'b0010);
    chk("p1_wren_line2", lg_wren[2*W], 4'b0100);
    chk("p1_wren_line3", lg_wren[3*W], 4'b1000);
    first_rd = -1; first_int = -1;
    for (int i = 0; i < 100; i++) begin
      if (first_rd < 0 && lg_rd[i]) first_rd = i;
      if (first_int < 0 && lg_int[i]) first_int = i;
    end
    chk("p1_first_rd_cycle", first_rd, 3*W + 1);
    chk("p1_first_int_cycle", first_int, 4*W + 1);
    n = 0;
    for (int i = 0; i < 4*W + 1; i++) n += int'(lg_rd[i]);
    chk("p1_rd_count_line0", n, W);
    n = 0;
    for (int i = 0; i <= 4*W; i++) n += int'(!lg_ir[i]);
    chk("p1_in_ready_low_cycles", n, 1);
    chk("p1_rd_top_after_int", lg_top[4*W + 1], 1);
    chk("p1_coincide_wr", {lg_wren[5*W + 1], lg_wa[5*W + 1]}, {4'b0001, 4'(W - 1)});
    chk("p1_coincide_rd", {lg_rd[5*W + 1], lg_ra[5*W + 1]}, {1'b1, 4'(W - 1)});
    chk("p1_coincide_int", {lg_int[5*W + 2], lg_ir[5*W + 2]}, 2'b11);
    chk("p1_idle_bubble", {lg_rd[5*W + 2], lg_rd[5*W + 3]}, 2'b01);

    // Phase 2: out_ready alternating every cycle.
    do_reset(1'b1, 1'b1);
    for (int i = 1; i < 130; i++) begin
      @(posedge ACLK); #1;
      out_ready = (i % 2 == 0);
    end
    @(negedge ACLK); #1;
    first_rd = -1; first_int = -1; last_rd = -1;
    for (int i = 0; i < 130; i++) begin
      if (first_rd < 0 && lg_rd[i]) first_rd = i;
      if (first_int < 0 && lg_int[i]) first_int = i;
    end
    n = 0;
    for (int i = 0; i < 130; i++)
      if (first_int >= 0 && i < first_int && lg_rd[i]) begin
        last_rd = i; n++;
      end
    chk("p2_toggle_span", last_rd - first_rd, 2*W - 2);
    chk("p2_toggle_count", n, W);

    // Phase 3: one full frame with padding lines, random handshakes.
    do_reset(1'b0, 1'b0);
    for (k = 0; k < 4000 && fd_cnt == 0; k++) begin
      @(posedge ACLK); #1;
      in_valid  = (acc_cnt < (H + 2) * W) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("p3_frame_done_seen", fd_cnt, 1);
    in_valid = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("p3_int_count", int_cnt, H);
    chk("p3_fd_count", fd_cnt, 1);
    chk("p3_post_frame", {in_ready, rd_top, wr_addr, rd_addr, frame_done}, {1'b1, 2'd0, 4'd0, 4'd0, 1'b0});

    // Phase 4: asynchronous reset mid-line.
    in_valid = 1'b1;
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge ACLK); #1;
      out_ready = ($urandom_range(0, 1) != 0);
      if (wr_addr == CW'(10)) begin
        hit = 1;
        break;
      end
    end
    chk("p4_reached_col10", hit, 1);
    #2;
    ARESETn = 1'b0; in_valid = 1'b0;
    #1;
    chk("p4_async_ready_wr", {in_ready, wr_en, wr_addr}, {1'b1, 4'd0, 4'd0});
    chk("p4_async_rd", {rd_en, rd_top, rd_addr}, 0);
    chk("p4_async_flags", {win_valid, INT, frame_done}, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge ACLK); #1;
    chk("p4_first_write_after_rst", {wr_en, wr_addr}, {4'b0001, 4'd0});

    // Phase 5: long random run across several frames.
    for (int i = 0; i < 3000; i++) begin
      @(posedge ACLK); #1;
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge ACLK); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_scheduler.md
# line_buffer_scheduler

Control block for the edge-detection pipeline's line-buffer bank: it steers incoming stream pixels into one of NUM_BUF single-port line RAMs and sequences reads of three adjacent lines to form the 3x3 window feed. It owns the input-side ready, the per-line read schedule and the `INT` line-request pulse seen at the `image_top` boundary. It sits between the slave stream interface and the line RAMs/convolution stage inside `image_top`; it holds no pixel data itself.

## Interface
- `IMG_W`, 512: pixels per line.
- `IMG_H`, 512: output rows per frame.
- `NUM_BUF`, 4: line buffers in the bank; fixed at 4 in this design.
- `ACLK`  in  1  clock.
- `ARESETn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  pixel present on slave stream (`TVALID_sub`).
- `in_ready`  out  1  scheduler can accept a pixel (`TREADY_sub`).
- `wr_en`  out  NUM_BUF  one-hot write enable to the line RAMs.
- `wr_addr`  out  clog2(IMG_W)  write column.
- `out_ready`  in  1  downstream can accept a window column (`TREADY_man`).
- `rd_en`  out  1  read strobe to all three window RAMs.
- `rd_top`  out  2  index of the buffer holding the top window line.
- `rd_addr`  out  clog2(IMG_W)  read column.
- `win_valid`  out  1  `rd_en` delayed one cycle (RAM read latency).
- `INT`  out  1  one-cycle pulse: one line consumed, host may send next line.
- `frame_done`  out  1  one-cycle pulse after the IMG_H-th row is read.

## Operation
- Accept = `in_valid && in_ready`. On accept: `wr_en = 1 << wr_idx`, `wr_addr = wr_col`; `wr_col` increments.
- Write line complete (accept at `wr_col == IMG_W-1`): `wr_col` -> 0, `wr_idx` -> (`wr_idx`+1) mod 4, `fill` +1.
- `fill` (0..4) counts completed, unconsumed lines. `in_ready = (fill != 4)`, combinational from registered `fill`.
- FSM states IDLE, READ. IDLE -> READ when `fill >= 3`. In READ: `rd_en = out_ready`; each `rd_en` cycle increments `rd_col`.
- Read line complete (`rd_en` at `rd_col == IMG_W-1`): `rd_col` -> 0, `rd_top` -> (`rd_top`+1) mod 4, `fill` -1, `INT` pulses next cycle, row counter +1, FSM -> IDLE for exactly one cycle, then re-evaluates.
- Write complete and read complete in the same cycle: `fill` unchanged.
- Row counter reaching IMG_H: `frame_done` pulses with that row's `INT`; row counter, `rd_top`, `wr_idx` and `fill` return to 0; `wr_col` is already 0 because the host is idle.
- Write buffer `wr_idx` never equals any of `rd_top`..`rd_top`+2 (mod 4) while `fill <= 3`. This is guaranteed by the `in_ready` gating.
- The host appends two zero lines per frame for bottom padding; the scheduler treats them as normal lines.

## Timing
- Reset values: `in_ready`=1, `wr_en`=0, `wr_addr`=0, `rd_en`=0, `rd_top`=0, `rd_addr`=0, `win_valid`=0, `INT`=0, `frame_done`=0; FSM IDLE, all counters 0.
- `ARESETn` low mid-line: everything is cleared immediately, and any partial line is discarded.
- `wr_en` and `wr_addr` are combinational from the accept condition (same cycle).
- `rd_en` is combinational from state and `out_ready`. `win_valid` is registered, 1 cycle after `rd_en`.
- The first `rd_en` occurs no earlier than 1 cycle after `fill` becomes 3 (registered FSM).
- `INT` is registered: high for 1 cycle, the cycle after the last `rd_en` of a line.
- `out_ready` low in READ stalls `rd_col`; no bubbles are inserted other than the one IDLE cycle per line.

## Structure
- Shared package `edge_pkg`: `IMG_W`, `IMG_H`, `NUM_BUF` defaults, `COL_W = $clog2(IMG_W)`, the FSM state enum, and a `buf_idx_t` 2-bit type.
- One natural sub-module, `line_col_counter`: a column counter with enable, wrap at IMG_W and a wrap pulse. It is instantiated twice, for the write and read sides.

## Test plan
- Reset, then 4*512 pixels with `in_valid` constant and `out_ready`=1 -> `wr_en` cycles 0001, 0010, 0100, 1000 per line. READ starts after line 3. `in_ready` drops only while `fill`=4.
- After the first read line -> exactly 512 `rd_en` with `rd_top`=0, `rd_addr` 0..511, `INT` one cycle after the last, `rd_top`=1.
- Write of the last pixel of a line coinciding with the read of `rd_col`=511 -> `fill` holds its value and `INT` still pulses.
- `out_ready` toggled 1-0-1 every cycle during READ -> 512 `rd_en` over 1023 cycles, `win_valid` tracking `rd_en` by 1.
- Full 512-row frame plus two zero lines, driven by `INT` handshakes -> 512 `INT` pulses, a `frame_done` coincident with the last, and counters at 0 afterward.
- `ARESETn` pulsed low at `wr_col`=200 -> all outputs at reset values asynchronously, and the next accepted pixel writes buffer 0 at address 0.
